key_expand_inv: RTL and testbench

- Inverse AES-128 key schedule for the decryption datapath.
- Takes the final (round-10) round key and walks the schedule backwards, producing round keys 10, 9, ..., 0 in order, one per accepted transfer.
- Feeds the inverse-cipher round loop, which needs round keys in reverse order.
- Uses a valid/ready handshake so the round loop can stall it.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/s_box.sv | 29 ++
 rtl/key_expand_inv.sv | 152 +++++++++++++++
 tb/tb_key_expand_inv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 key schedule constants, state encodings and word helpers.
package aes_pkg;

   localparam int KEY_W  = 128;
   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

   // Word offsets into a [0:127] key; word a holds byte 0.
   localparam int WORD_A = 0;
   localparam int WORD_B = 32;
   localparam int WORD_C = 64;
   localparam int WORD_D = 96;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_FWD  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [0:31] rot_word(input logic [0:31] w);
      return {w[8:31], w[0:7]};
   endfunction

endpackage

// File: rtl/s_box.sv
// rtl/s_box.sv - AES forward S-box, one byte in (as high/low nibble), one byte out.
module s_box (
   input  logic [3:0] in_hi,
   input  logic [3:0] in_lo,
   output logic [7:0] out_byte
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign out_byte = SBOX[{in_hi, in_lo}];

endmodule

// File: rtl/key_expand_inv.sv
// rtl/key_expand_inv.sv - Inverse AES-128 key schedule emitting round keys 10..0 over valid/ready.
// Optional KEY_INV_FWD_DERIVE_EN: key_in is the cipher key and round 10 is derived first.
module key_expand_inv #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [0:127] key_in,
   input  logic         key_ready,
   output logic [0:127] round_key,
   output logic [3:0]   round_idx,
   output logic         key_valid,
   output logic         busy,
   output logic         done
);
   import aes_pkg::*;

   if (NR != 10) begin : g_nr_check
      $error("key_expand_inv: NR must be 10 for AES-128");
   end

   localparam logic [3:0] NR4 = 4'(NR);

   state_e         state_q, state_d;
   logic [0:127]   key_q, key_d;
   logic [3:0]     idx_q, idx_d;
   logic           valid_q, valid_d;

   logic [0:31]    w_a, w_b, w_c, w_d;
   logic [0:31]    inv_b, inv_c, inv_d;
   logic [0:31]    sub_src, sub_in, sub_out, sub_mix, new_a;
   logic [3:0]     rcon_idx;
   logic [0:127]   inv_key;

   assign w_a = key_q[WORD_A +: WORD_W];
   assign w_b = key_q[WORD_B +: WORD_W];
   assign w_c = key_q[WORD_C +: WORD_W];
   assign w_d = key_q[WORD_D +: WORD_W];

   assign inv_d = w_d ^ w_c;
   assign inv_c = w_c ^ w_b;
   assign inv_b = w_b ^ w_a;

`ifdef KEY_INV_FWD_DERIVE_EN
   logic [3:0]   cnt_q, cnt_d;
   logic [0:31]  fwd_b, fwd_c, fwd_d;
   logic [0:127] fwd_key;

   // Forward step rotates the raw last word; the inverse step rotates the recovered one.
   assign sub_src  = (state_q == ST_FWD) ? w_d : inv_d;
   assign rcon_idx = (state_q == ST_FWD) ? cnt_q : idx_q;

   assign fwd_b   = w_b ^ new_a;
   assign fwd_c   = w_c ^ fwd_b;
   assign fwd_d   = w_d ^ fwd_c;
   assign fwd_key = {new_a, fwd_b, fwd_c, fwd_d};
`else
   assign sub_src  = inv_d;
   assign rcon_idx = idx_q;
`endif

   assign sub_in = rot_word(sub_src);

   for (genvar g = 0; g < 4; g++) begin : g_sub_word
      s_box u_s_box (
         .in_hi    (sub_in[g*BYTE_W +: 4]),
         .in_lo    (sub_in[g*BYTE_W + 4 +: 4]),
         .out_byte (sub_out[g*BYTE_W +: BYTE_W])
      );
   end

   assign sub_mix = sub_out ^ {rcon(rcon_idx), 24'h000000};
   assign new_a   = w_a ^ sub_mix;
   assign inv_key = {new_a, inv_b, inv_c, inv_d};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      valid_d = valid_q;
`ifdef KEY_INV_FWD_DERIVE_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d = key_in;
`ifdef KEY_INV_FWD_DERIVE_EN
               cnt_d   = 4'd1;
               state_d = ST_FWD;
`else
               idx_d   = NR4;
               valid_d = 1'b1;
               state_d = ST_EMIT;
`endif
            end
         end
`ifdef KEY_INV_FWD_DERIVE_EN
         ST_FWD: begin
            key_d = fwd_key;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == NR4) begin
               idx_d   = NR4;
               valid_d = 1'b1;
               state_d = ST_EMIT;
            end
         end
`endif
         ST_EMIT: begin
            if (valid_q && key_ready) begin
               if (idx_q != 4'd0) begin
                  key_d = inv_key;
                  idx_d = idx_q - 4'd1;
               end else begin
                  valid_d = 1'b0;
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
`ifdef KEY_INV_FWD_DERIVE_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
`ifdef KEY_INV_FWD_DERIVE_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign round_key = key_q;
   assign round_idx = idx_q;
   assign key_valid = valid_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_key_expand_inv.sv
// tb/tb_key_expand_inv.sv - Randomized check of key_expand_inv against a forward-expansion model.
module tb_key_expand_inv;

`ifdef KEY_INV_FWD_DERIVE_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst, start, key_ready;
   logic [0:127] key_in, round_key;
   logic [3:0]   round_idx;
   logic         key_valid, busy, done;

   key_expand_inv #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .key_ready (key_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .key_valid (key_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: S-box from GF(2^8) inversion plus affine map, FIPS-197 forward expansion.
   logic [7:0]   sb [256];
   logic [127:0] mdl_rk [11];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic void build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[x] = s;
      end
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic void expand(input logic [127:0] cipher);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = cipher[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   exp_t exp_q[$];
   int   phase = 0;
   int   wait_cnt = 0;
   int   done_cnt = 0;
   bit   rst_seen = 1'b0;

   // Single compare process: observes handshake at mid-cycle and walks the expected key list.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (rst === 1'b1) begin
         phase    = 0;
         rst_seen = 1'b1;
         exp_q.delete();
      end else begin
         if (rst_seen) begin
            rst_seen = 1'b0;
            chk("reset_state", {round_key, round_idx, key_valid, busy, done}, '0);
         end
         if (phase == 3) begin
            chk("fin_state", {key_valid, busy, done}, 3'b011);
            phase = 0;
         end else if (phase == 0) begin
            chk("idle_state", {key_valid, busy, done}, 3'b000);
            if (start === 1'b1) begin
               for (int r = 10; r >= 0; r--) exp_q.push_back('{idx: 4'(r), key: mdl_rk[r]});
               phase    = 1;
               wait_cnt = 0;
            end
         end else begin
            if (phase == 1) begin
               wait_cnt++;
               if (key_valid === 1'b1) begin
                  chk("first_valid_latency", 136'(wait_cnt), 136'(LAT));
                  phase = 2;
               end else begin
                  chk("wait_busy", {busy, done}, 2'b10);
                  if (wait_cnt >= LAT) begin
                     chk("first_valid_timeout", 136'(key_valid), 136'(1));
                     phase = 0;
                     exp_q.delete();
                  end
               end
            end
            if (phase == 2) begin
               if (key_valid !== 1'b1 || exp_q.size() == 0) begin
                  chk("emit_valid", {key_valid, 1'b1}, {1'b1, exp_q.size() == 0});
                  phase = 0;
                  exp_q.delete();
               end else begin
                  chk("round_key", {round_idx, round_key, busy, done},
                      {exp_q[0].idx, exp_q[0].key, 1'b1, 1'b0});
                  if (key_ready === 1'b1) begin
                     if (exp_q[0].idx == 4'd0) phase = 3;
                     void'(exp_q.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic run_seq(input logic [127:0] cipher, input int ready_pct,
                          input bit spur, input bit bp7, input bit rst5);
      int hold = 0;
      bit seen = 1'b0;
      int d0;
      expand(cipher);
`ifdef KEY_INV_FWD_DERIVE_EN
      key_in = cipher;
`else
      key_in = mdl_rk[10];
`endif
      start     = 1'b1;
      key_ready = ($urandom_range(99) < 32'(ready_pct));
      @(posedge clk); #2;
      start = 1'b0;
      d0    = done_cnt;
      for (int c = 0; c < 400; c++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bp7 && key_valid && round_idx == 4'd7 && hold < 3) begin
            key_ready = 1'b0;
            hold++;
         end else begin
            key_ready = ($urandom_range(99) < 32'(ready_pct));
         end
         start = spur && key_valid && ($urandom_range(3) == 0);
         if (rst5 && key_valid && round_idx == 4'd5) begin
            rst   = 1'b1;
            start = 1'b0;
            @(posedge clk); #2;
            rst = 1'b0;
            key_ready = 1'b0;
            return;
         end
         @(posedge clk); #2;
      end
      start     = 1'b0;
      key_ready = 1'b0;
      chk("done_seen", 136'(seen), 136'(1));
      @(posedge clk); #2;
      chk("done_count", 136'(done_cnt - d0), 136'(1));
      chk("busy_after_done", {busy, done}, 2'b00);
   endtask

   localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      key_ready = 1'b0;
      key_in    = '0;
      build_sbox();
      chk("model_sbox_00", 136'(sb[8'h00]), 136'(8'h63));
      chk("model_sbox_53", 136'(sb[8'h53]), 136'(8'hed));
      expand(A1_KEY);
      chk("model_rk10", mdl_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("model_rk9",  mdl_rk[9],  128'hac7766f319fadc2128d12941575c006e);
      chk("model_rk1",  mdl_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
      chk("model_rk0",  mdl_rk[0],  A1_KEY);

      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk); #2;

      run_seq(A1_KEY, 100, 1'b0, 1'b0, 1'b0);
      run_seq(A1_KEY, 100, 1'b0, 1'b1, 1'b0);
      run_seq({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #2;
      run_seq(A1_KEY, 100, 1'b1, 1'b0, 1'b0);

      start  = 1'b1;
      rst    = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #2;
      start = 1'b0;
      rst   = 1'b0;
      repeat (3) @(posedge clk);
      #2;

      for (int n = 0; n < 20; n++)
         run_seq({$urandom, $urandom, $urandom, $urandom}, 40 + 3 * n, 1'b1, n[0], 1'b0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
